// File: rtl/load_reader.sv
// Load-side bus reader: AdEL check, word-aligned bus read, byte/half
// extraction with sign/zero extension, response held until accepted.
module load_reader #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic        exc_ldOv,
    output logic        req_ready,
    output logic        bus_rd_en,
    output logic [15:0] bus_addr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        exc_AdEL,
    output logic        exc_BusTO,
    input  logic        resp_ready
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LB  = 3'd4;
    localparam logic [2:0] OP_LBU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [15:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          adel_q, adel_d;
    logic          busto_q, busto_d;

    logic          op_ok;
    logic          misalign;
    logic          in_range;
    logic          periph_sub;
    logic          adel;
    logic [15:0]   half;
    logic [7:0]    bsel;
    logic [31:0]   ext;

    // Request-side decode, only meaningful at the accept edge
    always_comb begin
        op_ok      = (req_op >= OP_LW) && (req_op <= OP_LBU);
        misalign   = ((req_op == OP_LW) && (req_addr[1:0] != 2'b00)) ||
                     (((req_op == OP_LH) || (req_op == OP_LHU)) &&
                      req_addr[0]);
        in_range   = (req_addr <= 16'h2FFF) ||
                     ((req_addr >= 16'h7F00) && (req_addr <= 16'h7F0B)) ||
                     ((req_addr >= 16'h7F10) && (req_addr <= 16'h7F1B)) ||
                     ((req_addr >= 16'h7F20) && (req_addr <= 16'h7F23));
        periph_sub = (req_op != OP_LW) && (req_addr >= 16'h7F00);
        adel       = misalign || !in_range || periph_sub || exc_ldOv;
    end

    always_comb begin
        half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (addr_q[1:0])
            2'd0:    bsel = bus_rdata[7:0];
            2'd1:    bsel = bus_rdata[15:8];
            2'd2:    bsel = bus_rdata[23:16];
            default: bsel = bus_rdata[31:24];
        endcase
        ext = bus_rdata;
        unique case (1'b1)
            (op_q == OP_LH):  ext = {{16{half[15]}}, half};
            (op_q == OP_LHU): ext = {16'h0000, half};
            (op_q == OP_LB):  ext = {{24{bsel[7]}}, bsel};
            (op_q == OP_LBU): ext = {24'h000000, bsel};
            default:          ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        adel_d  = adel_q;
        busto_d = busto_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = '0;
            adel_d  = 1'b0;
            busto_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && op_ok) begin
                        op_d    = req_op;
                        addr_d  = req_addr;
                        cnt_d   = '0;
                        data_d  = '0;
                        busto_d = 1'b0;
                        adel_d  = adel;
                        state_d = adel ? HOLD : WAIT;
                    end
                end
                WAIT: begin
                    // Data arriving in the last allowed cycle beats timeout
                    if (bus_rvalid) begin
                        data_d  = ext;
                        state_d = HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        busto_d = 1'b1;
                        data_d  = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        state_d = IDLE;
                        data_d  = '0;
                        adel_d  = 1'b0;
                        busto_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            adel_q  <= 1'b0;
            busto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            adel_q  <= adel_d;
            busto_q <= busto_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign bus_rd_en  = (state_q == WAIT);
    assign resp_valid = (state_q == HOLD);
    assign bus_addr   = {addr_q[15:2], 2'b00};
    assign resp_data  = data_q;
    assign exc_AdEL   = adel_q;
    assign exc_BusTO  = busto_q;

endmodule

// File: doc/load_reader.md
# load_reader

Load-side bus reader for the P7 pipeline, the read-direction counterpart of the store byte-enable unit. It accepts one load request at a time from the M stage and checks it for AdEL. It then issues a word-aligned read on the data bus, waits for the returned word, and extracts and sign- or zero-extends the addressed byte or halfword. The result is held until the W side accepts it. It sits between the M-stage pipeline register and the system bridge (DM, timer0, timer1, interrupt generator).

## Interface
- `TIMEOUT`, default 16: maximum cycles in WAIT without `bus_rvalid` before a bus timeout is reported.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; forces the idle state.
- `flush` in 1: synchronous kill from exception or eret; overrides every other input.
- `req_valid` in 1: a load request is presented.
- `req_op` in 3: load type. 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6–7 treated as none.
- `req_addr` in 16: byte address.
- `exc_ldOv` in 1: address-calculation overflow for this request.
- `req_ready` out 1: high only in IDLE.
- `bus_rd_en` out 1: read strobe to the bridge.
- `bus_addr` out 16: latched address with bits [1:0] forced to 0.
- `bus_rdata` in 32: returned word; valid only with `bus_rvalid`.
- `bus_rvalid` in 1: bridge data valid. The bridge may assert it only while `bus_rd_en` is high.
- `resp_valid` out 1: response held.
- `resp_data` out 32: extended load data; 0 when any exception flag is set.
- `exc_AdEL` out 1: address error on load; qualified by `resp_valid`.
- `exc_BusTO` out 1: bus timeout; qualified by `resp_valid`.
- `resp_ready` in 1: W side accepts the response.

## Operation
- **States**: IDLE, WAIT, HOLD. Encoding is free.
- **Reset values**: state IDLE; `req_ready`=1; `bus_rd_en`=0; `bus_addr`=0; `resp_valid`=0; `resp_data`=0; `exc_AdEL`=0; `exc_BusTO`=0; timeout counter 0.
- **Accept**: a request is accepted when `req_valid`, `req_ready`, a valid op (1–5) and `!flush` all hold. Op, address and the error decision are latched at that edge. Requests with op 0 or 6–7 are ignored and the state stays IDLE.
- **AdEL** is the OR of the following, evaluated on request inputs at accept:
  - Misalignment: lw with `addr[1:0]`≠0, or lh/lhu with `addr[0]`=1.
  - Out of range: the address is outside 0x0000–0x2FFF, 0x7F00–0x7F0B, 0x7F10–0x7F1B and 0x7F20–0x7F23.
  - Peripheral sub-word load: any op other than lw at an address ≥ 0x7F00.
  - `exc_ldOv`=1.
- **Transitions**:
  - IDLE → HOLD on accept with AdEL. No bus access is made; `exc_AdEL`=1, `resp_data`=0.
  - IDLE → WAIT on accept without AdEL. The counter is cleared.
  - WAIT: `bus_rd_en`=1. On `bus_rvalid`=1, the extended data is latched and the state goes to HOLD.
  - WAIT timeout: otherwise the counter increments. When it reaches `TIMEOUT`-1 without `bus_rvalid`, the state goes to HOLD with `exc_BusTO`=1 and `resp_data`=0. `bus_rvalid` in that same cycle wins over timeout.
  - HOLD: `resp_valid`=1. Outputs stay stable until `resp_ready`=1, then the state goes to IDLE and all flags clear.
- **Extraction**, with A = latched `addr[1:0]` and D = `bus_rdata`:
  - lw: D.
  - lh/lhu: D[31:16] if A[1], else D[15:0]; sign-extended for lh, zero-extended for lhu.
  - lb/lbu: D[8A+7:8A]; sign-extended for lb, zero-extended for lbu.
- **Flush**: in any state, the next state is IDLE with `resp_valid`, flags and counter cleared. An in-flight read is abandoned. Bus rule guarantees no late `bus_rvalid`. A request presented in the flush cycle is not accepted.
- **Reset mid-operation**: every output returns to its reset value immediately, without waiting for a clock edge.

## Timing
- `req_ready` and `bus_rd_en` are decoded from state only; there is no combinational path from any request input to them.
- Error path: accept at edge 0, `resp_valid` high in cycle 1.
- Normal path: accept at edge 0, `bus_rd_en` high from cycle 1. With `bus_rvalid` in cycle 1, `resp_valid` is high in cycle 2. Each extra bus wait cycle adds one cycle.
- Timeout: `resp_valid` rises `TIMEOUT` cycles after entering WAIT.
- Back-to-back requests: HOLD→IDLE takes one edge after `resp_ready`, so the next accept is possible in the following cycle. Peak throughput is 1 load per 3 cycles.
- `bus_addr` and latched op/addr are stable for the whole of WAIT and HOLD.

## Test plan
- **lb sign-extend**: lb at 0x0002, `bus_rdata`=0x12F45678 in cycle 1 → `resp_valid` in cycle 2, `resp_data`=0xFFFFFFF4, `bus_addr`=0x0000.
- **lhu high half**: lhu at 0x1006, `bus_rdata`=0x8001ABCD, 3 bus wait cycles → `resp_data`=0x00008001, `resp_valid` in cycle 5.
- **AdEL cases**, each giving `resp_valid` in cycle 1, `exc_AdEL`=1, `resp_data`=0 and `bus_rd_en` never high:
  - lw at 0x0001;
  - lh at 0x7F04;
  - lw at 0x3000;
  - lw at 0x7F0C;
  - lw at 0x0000 with `exc_ldOv`=1.
- **Legal timer read**: lw at 0x7F08, data 0x00000123 → `exc_AdEL`=0, `resp_data`=0x00000123.
- **Timeout**: `TIMEOUT`=16 with `bus_rvalid` held at 0 → `exc_BusTO`=1 and `resp_valid` 16 cycles after entering WAIT. With `bus_rvalid` asserted in that final cycle, normal data is returned and `exc_BusTO`=0.
- **Flush, backpressure and reset**:
  - Flush in WAIT → IDLE next cycle, `bus_rd_en`=0, no response.
  - `resp_ready` held low for 4 cycles → outputs stable throughout, `req_ready`=0.
  - Async `reset` pulse mid-HOLD → `resp_valid`=0 before the next clock edge.
